// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - registered, handshaked RV32I/Zicsr(/M) decode control
//
// Purpose:
//   Accepts a 32-bit instruction over a valid/ready handshake, decodes it and
//   presents a registered control bundle with its own valid/ready. M-extension
//   ops (optional, macro MDEXT_EN) run through a multi-cycle sequencer that
//   holds off fetch for MUL_CYCLES / DIV_CYCLES. Illegal instructions are
//   flagged and counted in a saturating counter.
//
// Optional feature macro: MDEXT_EN
//   defined   : funct7=7'h01 R-type decodes as M ops; sequencer and md_busy live
//   undefined : those encodings are illegal; md_op/mulsel/divsel/md_busy are 0
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_ins, i_ins_valid        instruction word and its valid
//   o_ins_ready               block can accept an instruction this cycle
//   i_hazard                  load-use hazard, blocks accept
//   i_flush                   kill in-flight decode
//   i_out_ready, o_out_valid  bundle handshake
//   o_alusel .. o_rs2         registered control bundle
//   o_md_busy                 M sequencer busy
//   o_ill_count               saturating illegal-instruction count

module decode_ctrl_pipe #(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_ins,
  input  logic             i_ins_valid,
  output logic             o_ins_ready,
  input  logic             i_hazard,
  input  logic             i_flush,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [2:0]       o_alusel,
  output logic [1:0]       o_mulsel,
  output logic [1:0]       o_divsel,
  output logic [1:0]       o_md_op,
  output logic [2:0]       o_storecntrl,
  output logic [4:0]       o_loadcntrl,
  output logic [3:0]       o_cmpcntrl,
  output logic [5:0]       o_brcond,
  output logic             o_branch,
  output logic             o_memread,
  output logic             o_memwrite,
  output logic             o_regwrite,
  output logic             o_alusrc,
  output logic             o_compare,
  output logic             o_auipc,
  output logic             o_lui,
  output logic             o_jal,
  output logic             o_jalr,
  output logic [2:0]       o_csrsel,
  output logic             o_csrread,
  output logic             o_csrwrite,
  output logic             o_illegal_ins,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_ill_count
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [0:0] {S_IDLE, S_MD_BUSY} state_t;

  typedef struct packed {
    logic [2:0] alusel;
    logic [1:0] mulsel;
    logic [1:0] divsel;
    logic [1:0] md_op;
    logic [2:0] storecntrl;
    logic [4:0] loadcntrl;
    logic [3:0] cmpcntrl;
    logic [5:0] brcond;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
    logic       compare;
    logic       auipc;
    logic       lui;
    logic       jal;
    logic       jalr;
    logic [2:0] csrsel;
    logic       csrread;
    logic       csrwrite;
    logic       illegal_ins;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_md_load;
  ctrl_t            r_ctrl, w_dec;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_ill_count;
  logic             w_ill, w_accept, w_zero, w_md_done, w_go_busy;
  logic [6:0]       w_opcode, w_funct7;
  logic [2:0]       w_funct3;

  assign w_opcode = i_ins[6:0];
  assign w_funct3 = i_ins[14:12];
  assign w_funct7 = i_ins[31:25];
  assign w_zero   = (i_ins == 32'h0);

  assign o_ins_ready = (r_state == S_IDLE) && (!r_out_valid || i_out_ready)
                       && !i_hazard && !i_flush;
  assign w_accept    = i_ins_valid && o_ins_ready;

  // Instruction decode
  always_comb begin
    w_dec     = '0;
    w_ill     = 1'b0;
    w_dec.rd  = i_ins[11:7];
    w_dec.rs1 = i_ins[19:15];
    w_dec.rs2 = i_ins[24:20];
    case (w_opcode)
      7'b0110011: begin
        w_dec.regwrite = 1'b1;
        case (w_funct7)
          7'h00: begin
            case (w_funct3)
              3'b000: w_dec.alusel = 3'b000;
              3'b001: w_dec.alusel = 3'b101;
              3'b010: begin w_dec.compare = 1'b1; w_dec.cmpcntrl = 4'b0001; w_dec.alusel = 3'b001; end
              3'b011: begin w_dec.compare = 1'b1; w_dec.cmpcntrl = 4'b0010; w_dec.alusel = 3'b001; end
              3'b100: w_dec.alusel = 3'b100;
              3'b101: w_dec.alusel = 3'b110;
              3'b110: w_dec.alusel = 3'b011;
              default: w_dec.alusel = 3'b010;
            endcase
          end
          7'h20: begin
            if (w_funct3 == 3'b000)      w_dec.alusel = 3'b001;
            else if (w_funct3 == 3'b101) w_dec.alusel = 3'b111;
            else                         w_ill = 1'b1;
          end
`ifdef MDEXT_EN
          7'h01: begin
            if (w_funct3[2]) begin
              w_dec.md_op  = 2'b10;
              w_dec.divsel = w_funct3[1:0];
            end else begin
              w_dec.md_op  = 2'b01;
              w_dec.mulsel = w_funct3[1:0];
            end
          end
`endif
          default: w_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        case (w_funct3)
          3'b000: w_dec.alusel = 3'b000;
          3'b010: begin w_dec.compare = 1'b1; w_dec.cmpcntrl = 4'b0100; w_dec.alusel = 3'b001; end
          3'b011: begin w_dec.compare = 1'b1; w_dec.cmpcntrl = 4'b1000; w_dec.alusel = 3'b001; end
          3'b100: w_dec.alusel = 3'b100;
          3'b110: w_dec.alusel = 3'b011;
          3'b111: w_dec.alusel = 3'b010;
          3'b001: begin
            if (w_funct7 == 7'h00) w_dec.alusel = 3'b101;
            else                   w_ill = 1'b1;
          end
          default: begin
            if (w_funct7 == 7'h00)      w_dec.alusel = 3'b110;
            else if (w_funct7 == 7'h20) w_dec.alusel = 3'b111;
            else                        w_ill = 1'b1;
          end
        endcase
      end
      7'b0000011: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.memread  = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.loadcntrl = 5'b00001;
          3'b001:  w_dec.loadcntrl = 5'b00010;
          3'b010:  w_dec.loadcntrl = 5'b00100;
          3'b100:  w_dec.loadcntrl = 5'b01000;
          3'b101:  w_dec.loadcntrl = 5'b10000;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        w_dec.alusrc   = 1'b1;
        w_dec.memwrite = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.storecntrl = 3'b001;
          3'b001:  w_dec.storecntrl = 3'b010;
          3'b010:  w_dec.storecntrl = 3'b100;
          default: w_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        w_dec.branch = 1'b1;
        w_dec.alusel = 3'b001;
        case (w_funct3)
          3'b000:  w_dec.brcond = 6'b000001;
          3'b001:  w_dec.brcond = 6'b000010;
          3'b100:  w_dec.brcond = 6'b000100;
          3'b101:  w_dec.brcond = 6'b001000;
          3'b110:  w_dec.brcond = 6'b010000;
          3'b111:  w_dec.brcond = 6'b100000;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0110111: begin w_dec.lui   = 1'b1; w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1; end
      7'b0010111: begin w_dec.auipc = 1'b1; w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1; end
      7'b1101111: begin w_dec.jal   = 1'b1; w_dec.regwrite = 1'b1; end
      7'b1100111: begin
        if (w_funct3 == 3'b000) begin
          w_dec.jalr = 1'b1; w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      // FENCE is architecturally a no-op for this core: a valid, empty bundle
      7'b0001111: w_ill = 1'b0;
      7'b1110011: begin
        if (w_funct3[1:0] == 2'b00) begin
          w_ill = 1'b1;
        end else begin
          w_dec.csrsel   = w_funct3;
          w_dec.regwrite = 1'b1;
          w_dec.alusrc   = w_funct3[2];
          // CSRRW(I) skips the read for rd==x0; CSRRS/C(I) skip the write for rs1/uimm==0
          if (w_funct3[1:0] == 2'b01) begin
            w_dec.csrwrite = 1'b1;
            w_dec.csrread  = (i_ins[11:7] != 5'd0);
          end else begin
            w_dec.csrread  = 1'b1;
            w_dec.csrwrite = (i_ins[19:15] != 5'd0);
          end
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_dec             = '0;
      w_dec.illegal_ins = 1'b1;
      w_dec.rd          = i_ins[11:7];
      w_dec.rs1         = i_ins[19:15];
      w_dec.rs2         = i_ins[24:20];
    end
    if (w_dec.rd == 5'd0) w_dec.regwrite = 1'b0;
  end

  assign w_md_load = (w_dec.md_op == 2'b01) ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);

  // M sequencer: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // M sequencer: next state. A zero load count means single-cycle, no busy phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_md_done   = 1'b0;
    w_go_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_dec.md_op != 2'b00) && (w_md_load != '0)) begin
          w_state_nxt = S_MD_BUSY;
          w_cnt_nxt   = w_md_load;
          w_go_busy   = 1'b1;
        end
      end
      S_MD_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_md_done   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_md_done   = 1'b0;
      w_go_busy   = 1'b0;
    end
  end

  // Bundle, valid and illegal counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl      <= '0;
      r_out_valid <= 1'b0;
      r_ill_count <= '0;
    end else begin
      if (w_accept) r_ctrl <= w_zero ? '0 : w_dec;

      if (i_flush)                        r_out_valid <= 1'b0;
      else if (w_accept)                  r_out_valid <= !w_zero && !w_go_busy;
      else if (w_md_done)                 r_out_valid <= 1'b1;
      else if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;

      if (w_accept && !w_zero && w_dec.illegal_ins && (r_ill_count != {CNT_W{1'b1}}))
        r_ill_count <= r_ill_count + CNT_W'(1);
    end
  end

`ifdef MDEXT_EN
  assign o_md_busy = (r_state == S_MD_BUSY);
`else
  assign o_md_busy = 1'b0;
`endif

  assign o_out_valid   = r_out_valid;
  assign o_ill_count   = r_ill_count;
  assign o_alusel      = r_ctrl.alusel;
  assign o_mulsel      = r_ctrl.mulsel;
  assign o_divsel      = r_ctrl.divsel;
  assign o_md_op       = r_ctrl.md_op;
  assign o_storecntrl  = r_ctrl.storecntrl;
  assign o_loadcntrl   = r_ctrl.loadcntrl;
  assign o_cmpcntrl    = r_ctrl.cmpcntrl;
  assign o_brcond      = r_ctrl.brcond;
  assign o_branch      = r_ctrl.branch;
  assign o_memread     = r_ctrl.memread;
  assign o_memwrite    = r_ctrl.memwrite;
  assign o_regwrite    = r_ctrl.regwrite;
  assign o_alusrc      = r_ctrl.alusrc;
  assign o_compare     = r_ctrl.compare;
  assign o_auipc       = r_ctrl.auipc;
  assign o_lui         = r_ctrl.lui;
  assign o_jal         = r_ctrl.jal;
  assign o_jalr        = r_ctrl.jalr;
  assign o_csrsel      = r_ctrl.csrsel;
  assign o_csrread     = r_ctrl.csrread;
  assign o_csrwrite    = r_ctrl.csrwrite;
  assign o_illegal_ins = r_ctrl.illegal_ins;
  assign o_rd          = r_ctrl.rd;
  assign o_rs1         = r_ctrl.rs1;
  assign o_rs2         = r_ctrl.rs2;

endmodule
